fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decoder. Owns the PC, issues word-aligned requests to instruction memory over a valid/ready request channel with fixed-order responses, and buffers returned words in a small queue. Presents {inst, inst_pc} to the decoder with a valid/ready handshake. Accepts a redirect from execute (branch/jal/jalr), which flushes the queue and discards in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_queue.sv | 56 +++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants, queue payload type and PC helper for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST    = 32'h0000_0013;
  localparam logic [XLEN-1:0] IALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Sequential fetch advance; wraps at the top of the address space.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush, used for both the instruction queue and the
// issued-address tag queue of the fetch stage. Head is read combinationally.
module fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot being written, so push into a full queue is fine alongside it.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && full && !do_pop)) else $error("fetch_queue: push into full queue");
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, instruction queue
// and redirect flush. Optional performance counters under FETCH_PERF_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc;
  logic [31:0]   pc_hold;
  logic [31:0]   tag_head;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop;
  logic [CW-1:0] q_count;
  logic [CW-1:0] t_count;
  logic          q_full;
  logic          q_empty;
  logic          t_full;
  logic          t_empty;
  logic          q_push;
  logic          q_pop;
  logic          req_fire;
  logic          credit_ok;
  logic [CW:0]   inflight;
  fetch_entry_t  q_din;
  fetch_entry_t  q_head;
  logic          unused_flags;

  // Credits: in-flight requests plus queued words, with this cycle's pop returned early.
  assign q_pop     = !q_empty && inst_ready;
  assign inflight  = (CW+1)'(outstanding) + (CW+1)'(q_count) - (CW+1)'(q_pop);
  assign credit_ok = inflight < (CW+1)'(DEPTH);

  assign imem_req_valid  = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr   = pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  assign q_push = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign q_din  = '{inst: imem_rsp_data, pc: tag_head};

  assign inst_valid = !q_empty;
  assign inst       = q_empty ? NOP_INST : q_head.inst;
  assign inst_pc    = q_empty ? pc_hold  : q_head.pc;

  assign unused_flags = ^{q_full, t_full, t_count};

  fetch_queue #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Tag queue tracks every issued address, including those later dropped.
  fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (imem_rsp_valid),
    .flush (1'b0),
    .din   (pc),
    .dout  (tag_head),
    .full  (t_full),
    .empty (t_empty),
    .count (t_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      pc_hold     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (!q_empty) pc_hold <= q_head.pc;
      if (redirect_valid) begin
        pc   <= redirect_pc & IALIGN_MASK;
        drop <= outstanding_nxt;
      end else begin
        if (req_fire) pc <= next_pc(pc);
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && t_empty)) else $error("fetch_unit: response without request");
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(q_pop);
      perf_stall   <= perf_stall + 32'(inst_valid && !inst_ready);
      perf_flush   <= perf_flush + 32'(redirect_valid);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomised memory model, directed redirect
// and stall scenarios, decoder-side monitor comparing against a PC-stream model.
module tb_fetch_unit;

  localparam logic [31:0] KEY   = 32'hA5A5_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] AMASK = 32'hFFFF_FFFC;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t        sb[$];
  logic [31:0] sb_next;
  mreq_t       pend[$];
  logic [31:0] exp_req_addr = 32'h0000_0000;

  int mem_ready_pct  = 100;
  int lat_min        = 1;
  int lat_max        = 1;
  int last_due       = 0;
  int fire_cnt       = 0;
  int first_fire_cyc = -1;
  int first_valid_cyc = -1;
  int valid_cnt      = 0;
  int pop_cnt        = 0;
  int stall_cnt      = 0;
  int rdr_cnt        = 0;
  bit last_rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected decoder stream is simply consecutive words from the last fetch origin.
  task automatic sb_fill();
    while (sb.size() < 64) begin
      sb.push_back('{inst: sb_next ^ KEY, pc: sb_next});
      sb_next = sb_next + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] base);
    sb.delete();
    sb_next = base;
    sb_fill();
  endtask

  task automatic tick(input logic rv, input logic [31:0] rpc, input logic ir, input bit on_rsp);
    @(negedge clk);
    if (on_rsp) rv = rv && (pend.size() != 0) && (pend[0].due <= cyc);
    last_rv        = rv;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = ir;
    #2;
    if (rv && !rst) begin
      sb_restart(rpc & AMASK);
      exp_req_addr = rpc & AMASK;
    end
    sb_fill();
  endtask

  task automatic wait_pops(input int n, input int budget);
    int p0;
    int k;
    p0 = pop_cnt;
    k  = 0;
    while ((pop_cnt - p0) < n && k < budget) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      k++;
    end
    checks++;
    if ((pop_cnt - p0) < n) begin
      errors++;
      $display("FAIL pop_timeout got=%0d required=%0d", pop_cnt - p0, n);
    end
  endtask

  // Memory model: in-order responses, data derived from address.
  initial begin
    int due;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      imem_req_ready = ($urandom_range(99) < mem_ready_pct);
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend[0].addr ^ KEY;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      #1;
      if (imem_rsp_valid) void'(pend.pop_front());
      if (!rst && imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
        if (first_fire_cyc < 0) first_fire_cyc = cyc;
        fire_cnt++;
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{addr: imem_req_addr, due: due});
      end
    end
  end

  // Decoder-side monitor.
  initial begin
    exp_t        e;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (inst_valid) begin
          valid_cnt++;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (prev_stall) begin
            chk("stall_inst_stable", inst, prev_inst);
            chk("stall_pc_stable", inst_pc, prev_pc);
          end
          if (inst_ready) begin
            pop_cnt++;
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_underflow actual_pc=%08h", inst_pc);
            end else begin
              e = sb.pop_front();
              chk("inst", inst, e.inst);
              chk("inst_pc", inst_pc, e.pc);
            end
          end else begin
            stall_cnt++;
          end
        end else begin
          chk("nop_when_empty", inst, NOP);
        end
        if (redirect_valid) rdr_cnt++;
        prev_stall = inst_valid && !inst_ready && !redirect_valid;
        prev_inst  = inst;
        prev_pc    = inst_pc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int f0;
    int n;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    sb_restart(32'h0000_0000);

    repeat (2) tick(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 32'd0);

    // Streaming with 1-cycle memory.
    @(negedge clk);
    rst        = 1'b0;
    inst_ready = 1'b1;
    #2;
    repeat (5) tick(1'b0, 32'h0, 1'b1, 1'b0);
    v0 = valid_cnt;
    repeat (15) tick(1'b0, 32'h0, 1'b1, 1'b0);
    chk("first_latency", 32'(first_valid_cyc - first_fire_cyc), 32'd2);
    chk("steady_throughput", 32'(valid_cnt - v0), 32'd15);

    // Decoder stall then release.
    f0 = fire_cnt;
    repeat (10) tick(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if ((fire_cnt - f0) > DEPTH) begin
      errors++;
      $display("FAIL stall_req_bound actual=%0d required<=%0d", fire_cnt - f0, DEPTH);
    end
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    v0 = valid_cnt;
    repeat (10) tick(1'b0, 32'h0, 1'b1, 1'b0);
    chk("resume_no_gap", 32'(valid_cnt - v0), 32'd10);

    // Redirect with two stale requests in a 3-cycle memory.
    lat_min = 3;
    lat_max = 3;
    tick(1'b1, 32'h0000_0200, 1'b0, 1'b0);
    n = 0;
    while (pend.size() != 2 && n < 20) begin
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      n++;
    end
    chk("two_outstanding", 32'(pend.size()), 32'd2);
    lat_min = 1;
    lat_max = 1;
    tick(1'b1, 32'h0000_0102, 1'b1, 1'b0);
    wait_pops(6, 40);

    // Redirect coinciding with a response.
    lat_min = 2;
    lat_max = 2;
    repeat (3) tick(1'b0, 32'h0, 1'b1, 1'b0);
    n = 0;
    last_rv = 1'b0;
    while (!last_rv && n < 20) begin
      tick(1'b1, 32'h0000_0300, 1'b1, 1'b1);
      n++;
    end
    chk("redirect_on_rsp_hit", 32'(last_rv), 32'd1);
    wait_pops(6, 40);

    // Address wrap at top of memory.
    lat_min = 1;
    lat_max = 1;
    tick(1'b1, 32'hFFFF_FFF4, 1'b1, 1'b0);
    wait_pops(8, 40);

    // Randomised traffic.
    mem_ready_pct = 70;
    lat_min       = 1;
    lat_max       = 4;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      tick(($urandom_range(99) < 4), tgt, ($urandom_range(99) < 65), 1'b0);
    end

    mem_ready_pct = 100;
    wait_pops(10, 60);
    repeat (3) tick(1'b0, 32'h0, 1'b0, 1'b0);

`ifdef FETCH_PERF_EN
    @(negedge clk);
    chk("perf_fetched", perf_fetched, 32'(pop_cnt));
    chk("perf_stall", perf_stall, 32'(stall_cnt));
    chk("perf_flush", perf_flush, 32'(rdr_cnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
